// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the fetch PC and steps it through run/stall/halt/restart,
// buffering one branch target across an instruction-memory stall. Optional macro: PC_SEQ_BRANCH_COUNT_EN.
module pc_sequencer #(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt_req,
    input  logic            imem_ready,
    input  logic            branch,
    input  logic [PC_W-1:0] address,
    output logic [PC_W-1:0] pc,
    output logic            fetch_valid,
    output logic            branch_taken,
    output logic            done
`ifdef PC_SEQ_BRANCH_COUNT_EN
    ,
    output logic [15:0]     branch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            pending_valid_reg, pending_valid_next;
    logic [PC_W-1:0] pending_addr_reg, pending_addr_next;
    logic            branch_taken_reg, branch_taken_next;
    logic            load_branch;
    logic            restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            pc_reg            <= RESET_PC;
            pending_valid_reg <= 1'b0;
            pending_addr_reg  <= '0;
            branch_taken_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            pending_valid_reg <= pending_valid_next;
            pending_addr_reg  <= pending_addr_next;
            branch_taken_reg  <= branch_taken_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        pc_next            = pc_reg;
        pending_valid_next = pending_valid_reg;
        pending_addr_next  = pending_addr_reg;
        branch_taken_next  = 1'b0;
        load_branch        = 1'b0;
        restart            = 1'b0;

        case (state_reg)
            IDLE: begin
                pc_next = RESET_PC;
                if (start) begin
                    state_next         = RUN;
                    pending_valid_next = 1'b0;
                    restart            = 1'b1;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_next = HALTED;
                end else if (!imem_ready) begin
                    // A branch seen during the stalling edge is parked, not applied.
                    state_next = STALL;
                    if (branch && !pending_valid_reg) begin
                        pending_valid_next = 1'b1;
                        pending_addr_next  = address;
                    end
                end else if (branch) begin
                    pc_next           = address;
                    branch_taken_next = 1'b1;
                    load_branch       = 1'b1;
                end else begin
                    pc_next = pc_reg + PC_ONE;
                end
            end
            STALL: begin
                if (halt_req) begin
                    state_next         = HALTED;
                    pending_valid_next = 1'b0;
                end else if (imem_ready) begin
                    state_next = RUN;
                    if (pending_valid_reg) begin
                        pc_next            = pending_addr_reg;
                        pending_valid_next = 1'b0;
                        branch_taken_next  = 1'b1;
                        load_branch        = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    state_next         = RUN;
                    pc_next            = RESET_PC;
                    pending_valid_next = 1'b0;
                    restart            = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = RESET_PC;
            end
        endcase
    end

    assign pc           = pc_reg;
    assign fetch_valid  = (state_reg == RUN);
    assign done         = (state_reg == HALTED);
    assign branch_taken = branch_taken_reg;

`ifdef PC_SEQ_BRANCH_COUNT_EN
    logic [15:0] count_reg, count_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (restart) begin
            count_next = '0;
        end else if (load_branch && (count_reg != 16'hFFFF)) begin
            count_next = count_reg + 16'd1;
        end
    end

    assign branch_count = count_reg;
`else
    logic unused_flags;
    assign unused_flags = load_branch ^ restart;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, async-reset sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_pc_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       halt_req;
    logic       imem_ready;
    logic       branch;
    logic [9:0] address;
    logic [9:0] pc;
    logic       fetch_valid;
    logic       branch_taken;
    logic       done;
`ifdef PC_SEQ_BRANCH_COUNT_EN
    logic [15:0] branch_count;
`endif

    pc_sequencer #(.PC_W(10), .RESET_PC(10'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .halt_req    (halt_req),
        .imem_ready  (imem_ready),
        .branch      (branch),
        .address     (address),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .branch_taken(branch_taken),
        .done        (done)
`ifdef PC_SEQ_BRANCH_COUNT_EN
        ,
        .branch_count(branch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) passed_checks++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: mode names and a one-deep queue for the parked branch target.
    localparam int M_IDLE = 0, M_RUN = 1, M_STALL = 2, M_HALT = 3;
    int       m_mode;
    int       m_pc;
    int       m_pend[$];
    int       m_bt;
    int       m_cnt;

    function automatic void model_reset();
        m_mode = M_IDLE; m_pc = 0; m_pend.delete(); m_bt = 0; m_cnt = 0;
    endfunction

    function automatic void model_take(input int target);
        m_pc  = target;
        m_bt  = 1;
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    endfunction

    function automatic void model_step(input bit s, input bit h, input bit r, input bit b, input int a);
        m_bt = 0;
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_RUN; m_pc = 0; m_cnt = 0; end
            M_RUN: begin
                if (h) m_mode = M_HALT;
                else if (!r) begin
                    m_mode = M_STALL;
                    if (b && m_pend.size() == 0) m_pend.push_back(a);
                end
                else if (b) model_take(a);
                else m_pc = (m_pc + 1) % 1024;
            end
            M_STALL: begin
                if (h) begin m_mode = M_HALT; m_pend.delete(); end
                else if (r) begin
                    m_mode = M_RUN;
                    if (m_pend.size() != 0) model_take(m_pend.pop_front());
                end
            end
            default: if (s) begin m_mode = M_RUN; m_pc = 0; m_pend.delete(); m_cnt = 0; end
        endcase
    endfunction

    task automatic drive_cycle(input bit s, input bit h, input bit r, input bit b, input logic [9:0] a);
        @(negedge clk);
        start = s; halt_req = h; imem_ready = r; branch = b; address = a;
        @(posedge clk);
        model_step(s, h, r, b, int'(a));
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"}, int'(pc), m_pc);
        check({tag, ".fetch_valid"}, int'(fetch_valid), int'(m_mode == M_RUN));
        check({tag, ".branch_taken"}, int'(branch_taken), m_bt);
        check({tag, ".done"}, int'(done), int'(m_mode == M_HALT));
`ifdef PC_SEQ_BRANCH_COUNT_EN
        check({tag, ".branch_count"}, int'(branch_count), m_cnt);
`endif
    endtask

    typedef struct {
        bit         s, h, r, b;
        logic [9:0] a;
        logic [9:0] exp_pc;
        bit         exp_fv, exp_bt, exp_done;
    } vec_t;

    vec_t vecs[20];

    initial begin
        //            s h r b  addr     pc     fv bt dn
        vecs[0]  = '{1,0,1,0, 10'h000, 10'h000, 1,0,0};
        vecs[1]  = '{0,0,1,0, 10'h000, 10'h001, 1,0,0};
        vecs[2]  = '{0,0,1,0, 10'h000, 10'h002, 1,0,0};
        vecs[3]  = '{0,0,1,0, 10'h000, 10'h003, 1,0,0};
        vecs[4]  = '{0,0,1,0, 10'h000, 10'h004, 1,0,0};
        vecs[5]  = '{0,0,1,0, 10'h000, 10'h005, 1,0,0};
        vecs[6]  = '{0,0,1,1, 10'h040, 10'h040, 1,1,0};
        vecs[7]  = '{0,0,1,0, 10'h000, 10'h041, 1,0,0};
        vecs[8]  = '{0,0,1,1, 10'h007, 10'h007, 1,1,0};
        vecs[9]  = '{0,0,0,1, 10'h100, 10'h007, 0,0,0};
        vecs[10] = '{0,0,0,1, 10'h200, 10'h007, 0,0,0};
        vecs[11] = '{1,0,0,0, 10'h000, 10'h007, 0,0,0};
        vecs[12] = '{0,0,1,0, 10'h000, 10'h100, 1,1,0};
        vecs[13] = '{0,0,1,0, 10'h000, 10'h101, 1,0,0};
        vecs[14] = '{0,0,1,1, 10'h3FF, 10'h3FF, 1,1,0};
        vecs[15] = '{0,0,1,0, 10'h000, 10'h000, 1,0,0};
        vecs[16] = '{0,0,1,1, 10'h00C, 10'h00C, 1,1,0};
        vecs[17] = '{0,1,1,1, 10'h055, 10'h00C, 0,0,1};
        vecs[18] = '{0,1,0,1, 10'h066, 10'h00C, 0,0,1};
        vecs[19] = '{1,0,1,0, 10'h000, 10'h000, 1,0,0};

        reset = 1'b0; start = 0; halt_req = 0; imem_ready = 0; branch = 0; address = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        reset = 1'b1;
        drive_cycle(0, 0, 1, 1, 10'h123);
        check_model("idle_hold");

        for (int i = 0; i < 20; i++) begin
            drive_cycle(vecs[i].s, vecs[i].h, vecs[i].r, vecs[i].b, vecs[i].a);
            $display("vec %0d: s=%0d h=%0d r=%0d b=%0d a=%h -> pc=%h fv=%0d bt=%0d done=%0d",
                     i, vecs[i].s, vecs[i].h, vecs[i].r, vecs[i].b, vecs[i].a,
                     pc, fetch_valid, branch_taken, done);
            check($sformatf("vec%0d.pc", i), int'(pc), int'(vecs[i].exp_pc));
            check($sformatf("vec%0d.fetch_valid", i), int'(fetch_valid), int'(vecs[i].exp_fv));
            check($sformatf("vec%0d.branch_taken", i), int'(branch_taken), int'(vecs[i].exp_bt));
            check($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].exp_done));
        end
`ifdef PC_SEQ_BRANCH_COUNT_EN
        check("count_after_restart", int'(branch_count), 0);
        drive_cycle(0, 0, 1, 1, 10'h010);
        drive_cycle(0, 0, 1, 1, 10'h020);
        drive_cycle(0, 0, 1, 1, 10'h030);
        drive_cycle(0, 0, 0, 1, 10'h040);
        drive_cycle(0, 0, 1, 0, 10'h000);
        check("count_four", int'(branch_count), 4);
`endif

        // Asynchronous reset in the middle of a stall with a parked branch.
        drive_cycle(0, 0, 1, 1, 10'h2F0);
        drive_cycle(0, 0, 0, 1, 10'h2AA);
        check_model("pre_reset_stall");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        $display("async reset mid-stall -> pc=%h fv=%0d bt=%0d done=%0d", pc, fetch_valid, branch_taken, done);
        check_model("async_reset");
        @(negedge clk);
        reset = 1'b1;
        drive_cycle(0, 0, 1, 0, 10'h000);
        check_model("post_reset_idle");
        drive_cycle(1, 0, 1, 0, 10'h000);
        check_model("post_reset_start");
        drive_cycle(0, 0, 1, 0, 10'h000);
        check_model("post_reset_run");
        check("pending_discarded", int'(pc), 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            bit s, h, r, b;
            logic [9:0] a;
            s = ($urandom_range(0, 99) < 8);
            h = ($urandom_range(0, 99) < 4);
            r = ($urandom_range(0, 99) < 75);
            b = ($urandom_range(0, 99) < 30);
            a = 10'($urandom_range(0, 1023));
            drive_cycle(s, h, r, b, a);
            check_model($sformatf("rand%0d", n));
        end

`ifdef PC_SEQ_BRANCH_COUNT_EN
        // Drive the counter to saturation with back-to-back direct branches.
        drive_cycle(0, 1, 1, 0, 10'h000);
        drive_cycle(1, 0, 1, 0, 10'h000);
        for (int n = 0; n < 65540; n++) drive_cycle(0, 0, 1, 1, 10'(n));
        check("count_saturated", int'(branch_count), 65535);
        drive_cycle(0, 0, 1, 1, 10'h001);
        check("count_stays_saturated", int'(branch_count), 65535);
        check_model("sat_model");
        drive_cycle(0, 1, 1, 0, 10'h000);
        drive_cycle(1, 0, 1, 0, 10'h000);
        check("count_cleared_by_start", int'(branch_count), 0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer for the single-cycle core. It sits downstream of the branch-decision logic and consumes its branch strobe and 10-bit target address.
- Holds the fetch PC and sequences run, stall, halt and restart.
- Buffers a branch decision that arrives while instruction memory is stalled.
- Drives the instruction-memory address and a fetch-valid qualifier.

Parameters:
PC_W, 10, program counter width in bits; target address width matches.
RESET_PC, 0, PC value loaded on reset and on every start.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  begin execution from RESET_PC; sampled in IDLE and HALTED.
halt_req  input  1  stop execution; sampled in RUN and STALL.
imem_ready  input  1  instruction memory can accept/advance this cycle.
branch  input  1  branch-taken strobe from the branch-decision logic.
address  input  PC_W  branch target, valid when branch=1.
pc  output  PC_W  current fetch address (registered).
fetch_valid  output  1  pc is being fetched this cycle (1 only in RUN).
branch_taken  output  1  registered one-cycle pulse: pc was loaded from a branch target on the previous edge.
done  output  1  high while in HALTED.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, pending_valid=0, pending_addr=0.
  - fetch_valid=0, branch_taken=0, done=0.
  - Deassertion is synchronised by the team's standard reset synchroniser outside this block.
- States: IDLE, RUN, STALL, HALTED. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - pc=RESET_PC.
  - start=1 -> RUN next edge, pc stays RESET_PC.
- RUN (fetch_valid=1). Priority per edge:
  1. halt_req=1 -> HALTED; pc held; branch ignored.
  2. imem_ready=0 -> STALL; pc held. If branch=1, capture pending_addr<=address, pending_valid<=1.
  3. branch=1 -> pc<=address; branch_taken=1 next cycle.
  4. Otherwise pc<=pc+1, modulo 2^PC_W (e.g. 1023 -> 0 for PC_W=10, no flag).
- STALL (fetch_valid=0, pc held):
  - halt_req=1 -> HALTED; pending_valid cleared; pending target discarded.
  - imem_ready=1 -> RUN. If pending_valid, pc<=pending_addr, pending_valid<=0, branch_taken=1 next cycle; otherwise pc held so the same address is re-fetched.
  - branch in STALL is ignored; the pending buffer holds one entry and the first capture wins.
- HALTED (done=1, fetch_valid=0, pc held):
  - start=1 -> RUN with pc<=RESET_PC, pending cleared, done=0 next cycle.
  - halt_req ignored.
- Timing:
  - Branch latency: target appears on pc one edge after branch is sampled in RUN.
  - Pending-branch latency: one edge after imem_ready returns.
- Simultaneous events:
  - halt_req beats stall and branch.
  - A stall in RUN beats direct branch application; the branch is buffered instead.
  - start in RUN/STALL is ignored.
- branch_taken is 0 in every cycle not immediately following a branch load.

Optional Feature:
- Macro: PC_SEQ_BRANCH_COUNT_EN.
- Defined:
  - Adds output branch_count [15:0].
  - Increments by 1 on every edge that loads pc from a branch target, direct or pending; saturates at 16'hFFFF.
  - Cleared by reset and by start.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start, imem_ready=1, no branch, 5 cycles -> pc 0,0,1,2,3,4; fetch_valid=1 from the first RUN cycle; branch_taken=0 throughout.
- RUN at pc=5, branch=1 with address=10'h040 -> pc=10'h040 next cycle; branch_taken=1 for exactly one cycle; then pc=10'h041.
- RUN at pc=7, imem_ready=0 with branch=1 and address=10'h100, imem_ready held 0 for 3 cycles, then 1 -> pc held 7 and fetch_valid=0 during the stall; pc=10'h100 and branch_taken=1 one edge after ready.
- pc=10'h3FF with no branch -> pc=0; halt_req and branch asserted together at pc=12 -> HALTED, pc=12, done=1; start -> pc=0, done=0.
- Drop reset to 0 mid-STALL with a pending branch -> all outputs reset immediately without a clock edge; after release and start, pc=0 and the pending target is never applied.
- With PC_SEQ_BRANCH_COUNT_EN defined: 3 direct branches plus 1 pending branch -> branch_count=4; branch_count preset to 16'hFFFF followed by a further branch -> stays 16'hFFFF; start -> 0.
